// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared widths, forward-select encodings, FSM states and the per-stage control shadow.
package pipe_hazard_ctl_pkg;

    localparam int unsigned RN_W  = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF   = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EALU = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MALU = 2'b10;
    localparam logic [FWD_W-1:0] FWD_MMEM = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MWAIT = 1'b1
    } state_t;

    // Control fields that travel down the pipe alongside an instruction.
    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic            wmem;
        logic [RN_W-1:0] rn;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctl_fwd_sel.sv
// Forwarding source select for one decode operand; the E stage takes priority over M.
module pipe_fwd_sel
    import pipe_hazard_ctl_pkg::*;
(
    input  logic [RN_W-1:0]  src,
    input  logic             used,
    input  stage_ctl_t       e_ctl,
    input  stage_ctl_t       m_ctl,
    output logic [FWD_W-1:0] fwd_c
);

    logic src_live;

    // Register 0 is hard-wired zero and never forwarded; a load in E cannot forward (load-use covers it).
    always_comb begin
        fwd_c    = FWD_RF;
        src_live = used && (src != '0);
        if (src_live && e_ctl.wreg && (e_ctl.rn == src) && !e_ctl.m2reg) begin
            fwd_c = FWD_EALU;
        end else if (src_live && m_ctl.wreg && (m_ctl.rn == src)) begin
            fwd_c = m_ctl.m2reg ? FWD_MMEM : FWD_MALU;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Interlock/forwarding controller: shadows D/E and E/M control, forwards operands,
// inserts load-use bubbles and holds the pipe while data memory is busy.
module pipe_hazard_ctl
    import pipe_hazard_ctl_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic [RN_W-1:0]  drs,
    input  logic [RN_W-1:0]  drt,
    input  logic             dusers,
    input  logic             dusert,
    input  logic             dwreg,
    input  logic             dm2reg,
    input  logic             dwmem,
    input  logic [RN_W-1:0]  drn,
    input  logic             mready,
    output logic [FWD_W-1:0] fwda,
    output logic [FWD_W-1:0] fwdb,
    output logic             wpcir,
    output logic             dbubble,
    output logic             pe,
    output logic [CNT_W-1:0] luse_cnt,
    output logic [CNT_W-1:0] mwait_cnt
);

    stage_ctl_t dec_ctl;
    stage_ctl_t e_q;
    stage_ctl_t m_q;
    state_t     state_q;
    state_t     state_d;
    logic       luse_c;
    logic       mbusy_c;

    // Gather the decode fields into the shadow payload format.
    always_comb begin
        dec_ctl.wreg  = dwreg;
        dec_ctl.m2reg = dm2reg;
        dec_ctl.wmem  = dwmem;
        dec_ctl.rn    = drn;
    end

    pipe_fwd_sel u_fwd_a (
        .src   (drs),
        .used  (dusers),
        .e_ctl (e_q),
        .m_ctl (m_q),
        .fwd_c (fwda)
    );

    pipe_fwd_sel u_fwd_b (
        .src   (drt),
        .used  (dusert),
        .e_ctl (e_q),
        .m_ctl (m_q),
        .fwd_c (fwdb)
    );

    // Load in E whose destination is read by the decode instruction.
    always_comb begin
        luse_c  = e_q.wreg && e_q.m2reg && (e_q.rn != '0) &&
                  ((dusers && (e_q.rn == drs)) || (dusert && (e_q.rn == drt)));
        mbusy_c = (m_q.m2reg || m_q.wmem) && !mready;
    end

    // Shadow E and M stage controls; a bubble enters E as all-zero controls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e_q <= '0;
            m_q <= '0;
        end else if (pe) begin
            e_q <= dbubble ? stage_ctl_t'('0) : dec_ctl;
            m_q <= e_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline enables; memory wait outranks load-use.
    always_comb begin
        state_d = state_q;
        pe      = 1'b1;
        wpcir   = 1'b1;
        dbubble = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (mbusy_c) begin
                    state_d = ST_MWAIT;
                    pe      = 1'b0;
                    wpcir   = 1'b0;
                end else if (luse_c) begin
                    wpcir   = 1'b0;
                    dbubble = 1'b1;
                end
            end
            ST_MWAIT: begin
                pe    = 1'b0;
                wpcir = 1'b0;
                if (mready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating stall statistics.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            luse_cnt  <= '0;
            mwait_cnt <= '0;
        end else begin
            if (luse_c && pe && (luse_cnt != '1)) begin
                luse_cnt <= luse_cnt + CNT_W'(1);
            end
            if (!pe && (mwait_cnt != '1)) begin
                mwait_cnt <= mwait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: forwarding, load-use bubbles, memory waits and reset.
module tb_pipe_hazard_ctl;
    import pipe_hazard_ctl_pkg::*;

    logic             clock;
    logic             resetn;
    logic [RN_W-1:0]  drs, drt, drn;
    logic             dusers, dusert, dwreg, dm2reg, dwmem, mready;
    logic [FWD_W-1:0] fwda, fwdb;
    logic             wpcir, dbubble, pe;
    logic [CNT_W-1:0] luse_cnt, mwait_cnt;

    int n_pass;
    int n_total;

    pipe_hazard_ctl dut (
        .clock     (clock),
        .resetn    (resetn),
        .drs       (drs),
        .drt       (drt),
        .dusers    (dusers),
        .dusert    (dusert),
        .dwreg     (dwreg),
        .dm2reg    (dm2reg),
        .dwmem     (dwmem),
        .drn       (drn),
        .mready    (mready),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .wpcir     (wpcir),
        .dbubble   (dbubble),
        .pe        (pe),
        .luse_cnt  (luse_cnt),
        .mwait_cnt (mwait_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one decode instruction: rs, rt, uses, uset, wreg, m2reg, wmem, rn.
    task automatic set_dec(input int rs, input int rt, input bit us, input bit ut,
                           input bit wr, input bit ld, input bit st, input int rn);
        drs    = RN_W'(rs);
        drt    = RN_W'(rt);
        dusers = us;
        dusert = ut;
        dwreg  = wr;
        dm2reg = ld;
        dwmem  = st;
        drn    = RN_W'(rn);
        #1;
    endtask

    task automatic set_nop();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        set_nop();
        mready = 1'b1;
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mready = 1'b1;
        set_dec(3, 4, 1, 1, 1, 0, 0, 5);
        n_total++; if (pe !== 1'b1) $display("FAIL reset_pe: got %b want 1", pe); else n_pass++;
        n_total++; if (wpcir !== 1'b1) $display("FAIL reset_wpcir: got %b want 1", wpcir); else n_pass++;
        n_total++; if (dbubble !== 1'b0) $display("FAIL reset_dbubble: got %b want 0", dbubble); else n_pass++;
        n_total++; if ({fwda, fwdb} !== 4'b0000) $display("FAIL reset_fwd: got %b%b want 0000", fwda, fwdb); else n_pass++;
        n_total++; if ({luse_cnt, mwait_cnt} !== 32'd0) $display("FAIL reset_cnt: got %0d/%0d want 0/0", luse_cnt, mwait_cnt); else n_pass++;
        tick();
        do_reset();
    endtask

    task automatic test_forward();
        do_reset();
        set_dec(1, 2, 1, 1, 1, 0, 0, 3);          // add r3,r1,r2
        tick();
        set_dec(3, 1, 1, 1, 1, 0, 0, 3);          // add r3,r3,r1 (E=add r3)
        n_total++; if (fwda !== FWD_EALU) $display("FAIL fwd_e_alu: got %b want 01", fwda); else n_pass++;
        n_total++; if (fwdb !== FWD_RF) $display("FAIL fwd_b_rf: got %b want 00", fwdb); else n_pass++;
        tick();
        set_dec(3, 3, 1, 1, 0, 0, 1, 0);          // sw reads r3 twice; E and M both write r3
        n_total++; if ({fwda, fwdb} !== {FWD_EALU, FWD_EALU}) $display("FAIL fwd_e_priority: got %b%b want 0101", fwda, fwdb); else n_pass++;
        tick();
        set_dec(3, 3, 1, 0, 1, 0, 0, 7);          // independent reader of r3; rt unused
        n_total++; if (fwda !== FWD_MALU) $display("FAIL fwd_m_alu: got %b want 10", fwda); else n_pass++;
        n_total++; if (fwdb !== FWD_RF) $display("FAIL fwd_unused: got %b want 00", fwdb); else n_pass++;
        n_total++; if ({pe, wpcir, dbubble} !== 3'b110) $display("FAIL fwd_no_stall: got %b want 110", {pe, wpcir, dbubble}); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(1, 0, 1, 0, 1, 1, 0, 5);          // lw r5
        tick();
        set_dec(5, 2, 1, 1, 1, 0, 0, 6);          // add r6,r5,r2
        n_total++; if ({pe, wpcir, dbubble} !== 3'b101) $display("FAIL luse_bubble: got %b want 101", {pe, wpcir, dbubble}); else n_pass++;
        n_total++; if (fwda !== FWD_RF) $display("FAIL luse_fwd_e_load: got %b want 00", fwda); else n_pass++;
        tick();
        n_total++; if (luse_cnt !== 16'd1) $display("FAIL luse_cnt: got %0d want 1", luse_cnt); else n_pass++;
        n_total++; if ({pe, wpcir, dbubble} !== 3'b110) $display("FAIL luse_resume: got %b want 110", {pe, wpcir, dbubble}); else n_pass++;
        n_total++; if (fwda !== FWD_MMEM) $display("FAIL luse_fwd_mmem: got %b want 11", fwda); else n_pass++;
        tick();
        n_total++; if ({luse_cnt, mwait_cnt} !== {16'd1, 16'd0}) $display("FAIL luse_cnt_once: got %0d/%0d want 1/0", luse_cnt, mwait_cnt); else n_pass++;
    endtask

    task automatic test_reg_zero();
        do_reset();
        set_dec(1, 0, 1, 0, 1, 1, 0, 5);          // lw r5
        tick();
        set_dec(0, 0, 1, 1, 1, 0, 0, 0);          // add r0,r0,r0
        n_total++; if ({wpcir, dbubble, fwda, fwdb} !== 6'b100000) $display("FAIL r0_after_lw: got %b want 100000", {wpcir, dbubble, fwda, fwdb}); else n_pass++;
        tick();
        set_dec(1, 0, 1, 0, 1, 1, 0, 0);          // lw r0
        tick();
        set_dec(0, 0, 1, 1, 1, 0, 0, 1);          // add r1,r0,r0 after lw r0
        n_total++; if ({wpcir, dbubble, fwda, fwdb} !== 6'b100000) $display("FAIL r0_lw_dest: got %b want 100000", {wpcir, dbubble, fwda, fwdb}); else n_pass++;
        tick();
        set_dec(0, 0, 1, 1, 0, 0, 0, 0);          // reads r0 while M holds write to r0 (M=add r0? no: lw r0)
        n_total++; if ({fwda, fwdb} !== 4'b0000) $display("FAIL r0_m_stage: got %b%b want 0000", fwda, fwdb); else n_pass++;
        n_total++; if (luse_cnt !== 16'd0) $display("FAIL r0_luse_cnt: got %0d want 0", luse_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_dec(1, 0, 1, 0, 1, 1, 0, 5);          // lw r5
        tick();
        set_nop();
        tick();                                   // lw now in M
        set_dec(5, 1, 1, 1, 1, 0, 0, 8);          // add r8,r5,r1
        mready = 1'b0;
        #1;
        n_total++; if ({pe, wpcir, dbubble} !== 3'b000) $display("FAIL mw_hold1: got %b want 000", {pe, wpcir, dbubble}); else n_pass++;
        tick();
        n_total++; if ({pe, wpcir, fwda} !== 4'b0011) $display("FAIL mw_hold2: got %b want 0011", {pe, wpcir, fwda}); else n_pass++;
        tick();
        mready = 1'b1;
        #1;
        n_total++; if ({pe, wpcir, fwda} !== 4'b0011) $display("FAIL mw_hold3: got %b want 0011", {pe, wpcir, fwda}); else n_pass++;
        tick();
        n_total++; if (mwait_cnt !== 16'd3) $display("FAIL mw_cnt: got %0d want 3", mwait_cnt); else n_pass++;
        n_total++; if ({pe, wpcir, dbubble, fwda} !== 5'b11011) $display("FAIL mw_resume: got %b want 11011", {pe, wpcir, dbubble, fwda}); else n_pass++;
        tick();
        n_total++; if (mwait_cnt !== 16'd3) $display("FAIL mw_cnt_stable: got %0d want 3", mwait_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_dec(1, 0, 1, 0, 1, 1, 0, 9);          // lw r9
        tick();
        set_dec(1, 0, 1, 0, 1, 1, 0, 5);          // lw r5
        tick();                                   // E=lw r5, M=lw r9
        set_dec(5, 2, 1, 1, 1, 0, 0, 6);          // add r6,r5,r2
        mready = 1'b0;
        #1;
        n_total++; if ({pe, wpcir, dbubble} !== 3'b000) $display("FAIL bb_wait_first: got %b want 000", {pe, wpcir, dbubble}); else n_pass++;
        tick();
        mready = 1'b1;
        #1;
        n_total++; if ({pe, wpcir, dbubble} !== 3'b000) $display("FAIL bb_wait_exit: got %b want 000", {pe, wpcir, dbubble}); else n_pass++;
        tick();
        n_total++; if ({pe, wpcir, dbubble} !== 3'b101) $display("FAIL bb_bubble: got %b want 101", {pe, wpcir, dbubble}); else n_pass++;
        n_total++; if ({luse_cnt, mwait_cnt} !== {16'd0, 16'd2}) $display("FAIL bb_cnt_pre: got %0d/%0d want 0/2", luse_cnt, mwait_cnt); else n_pass++;
        tick();
        n_total++; if ({pe, wpcir, dbubble, fwda} !== 5'b11011) $display("FAIL bb_after: got %b want 11011", {pe, wpcir, dbubble, fwda}); else n_pass++;
        n_total++; if (luse_cnt !== 16'd1) $display("FAIL bb_luse_cnt: got %0d want 1", luse_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_dec(1, 0, 1, 0, 1, 1, 0, 5);          // lw r5
        tick();
        set_nop();
        tick();
        set_dec(5, 0, 1, 0, 1, 0, 0, 6);
        mready = 1'b0;
        tick();
        tick();
        n_total++; if ({pe, mwait_cnt} !== {1'b0, 16'd2}) $display("FAIL rst_pre: got %b/%0d want 0/2", pe, mwait_cnt); else n_pass++;
        resetn = 1'b0;
        #1;
        n_total++; if ({pe, wpcir, dbubble, fwda} !== 5'b11000) $display("FAIL rst_async: got %b want 11000", {pe, wpcir, dbubble, fwda}); else n_pass++;
        n_total++; if ({luse_cnt, mwait_cnt} !== 32'd0) $display("FAIL rst_cnt: got %0d/%0d want 0/0", luse_cnt, mwait_cnt); else n_pass++;
        set_nop();
        resetn = 1'b1;
        tick();
        n_total++; if ({pe, wpcir, dbubble, mwait_cnt} !== {3'b110, 16'd0}) $display("FAIL rst_run: got %b/%0d want 110/0", {pe, wpcir, dbubble}, mwait_cnt); else n_pass++;
        mready = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        resetn  = 1'b0;
        mready  = 1'b1;
        set_nop();
        test_reset();
        test_forward();
        test_load_use();
        test_reg_zero();
        test_mem_wait();
        test_back_to_back();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
